// File: rtl/hub75_bcm_scan.sv
// HUB75/HUB75E scan controller: shifts one BCM bit-plane per pass,
// LSB plane first, with display time doubling per plane.
module hub75_bcm_scan #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int DEPTH    = 5,
  parameter int BASE_CYC = 8
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              enable,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  rd_addr,
  output logic                              rd_en,
  input  logic [6*DEPTH-1:0]                rd_data,
  output logic [5:0]                        rgb,
  output logic [ROW_BITS-1:0]               lines,
  output logic                              hub_ck,
  output logic                              hub_st,
  output logic                              hub_oe,
  output logic                              frame_start
);

  localparam int CB = $clog2(COLS);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHOWMAX = BASE_CYC << (DEPTH - 1);
  localparam int SHIFTN = 2 * COLS + 2;
  localparam int CW =
    $clog2((SHIFTN > SHOWMAX) ? SHIFTN : SHOWMAX) + 1;
  localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFTN - 1);
  localparam logic [CW-1:0] RD_END = CW'(2 * COLS);
  localparam logic [PW-1:0] PLANE_LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_LATCH, S_SHOW
  } state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [ROW_BITS-1:0]      r_row;
  logic [PW-1:0]            r_plane;
  logic [ROW_BITS+CB-1:0]   r_rd_addr;
  logic                     r_rd_en;
  logic [5:0]               r_rgb;
  logic [ROW_BITS-1:0]      r_lines;
  logic                     r_ck;
  logic                     r_st;
  logic                     r_oe;
  logic                     r_fs;

  logic [CW-1:0]            w_nk;
  logic [CW-1:0]            w_show_last;
  logic                     w_last_plane;
  logic [ROW_BITS-1:0]      w_nrow;
  logic [PW-1:0]            w_nplane;
  logic [DEPTH-1:0]         w_ch;
  logic [5:0]               w_bits;

  assign w_nk = r_cnt + CW'(1);
  assign w_show_last = (CW'(BASE_CYC) << r_plane) - CW'(1);
  assign w_last_plane = (r_plane == PLANE_LAST);
  assign w_nrow = w_last_plane ? r_row + ROW_BITS'(1) : r_row;
  assign w_nplane = w_last_plane ? '0 : r_plane + PW'(1);

  // Pick bit `plane` out of each of the six colour channels.
  always_comb begin
    w_ch = '0;
    w_bits = '0;
    for (int i = 0; i < 6; i++) begin
      w_ch = rd_data[i*DEPTH +: DEPTH];
      w_bits[i] = w_ch[r_plane];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_row     <= '0;
      r_plane   <= '0;
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_rgb     <= '0;
      r_lines   <= '0;
      r_ck      <= 1'b0;
      r_st      <= 1'b0;
      r_oe      <= 1'b1;
      r_fs      <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_row   <= '0;
          r_plane <= '0;
          r_cnt   <= '0;
          if (enable) begin
            r_state   <= S_SHIFT;
            r_fs      <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        S_SHIFT: begin
          if (r_cnt == SHIFT_LAST) begin
            r_state <= S_LATCH;
            r_st    <= 1'b1;
            r_ck    <= 1'b0;
            r_rd_en <= 1'b0;
            r_lines <= r_row;
          end else begin
            r_cnt     <= w_nk;
            r_rd_en   <= !w_nk[0] && (w_nk < RD_END);
            r_rd_addr <= {r_row, w_nk[CB:1]};
            r_ck      <= w_nk[0] && (w_nk > CW'(1));
            // RAM word arrives one cycle after its read strobe.
            if (!w_nk[0] && (w_nk > CW'(1)))
              r_rgb <= w_bits;
          end
        end
        S_LATCH: begin
          r_state <= S_SHOW;
          r_st    <= 1'b0;
          r_oe    <= 1'b0;
          r_cnt   <= '0;
        end
        S_SHOW: begin
          if (r_cnt == w_show_last) begin
            r_oe  <= 1'b1;
            r_cnt <= '0;
            if (enable) begin
              r_state   <= S_SHIFT;
              r_row     <= w_nrow;
              r_plane   <= w_nplane;
              r_rd_en   <= 1'b1;
              r_rd_addr <= {w_nrow, {CB{1'b0}}};
              r_fs      <= (w_nrow == '0) && (w_nplane == '0);
            end else begin
              r_state   <= S_IDLE;
              r_rgb     <= '0;
              r_row     <= '0;
              r_plane   <= '0;
              r_rd_addr <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_addr     = r_rd_addr;
  assign rd_en       = r_rd_en;
  assign rgb         = r_rgb;
  assign lines       = r_lines;
  assign hub_ck      = r_ck;
  assign hub_st      = r_st;
  assign hub_oe      = r_oe;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Randomized bench for hub75_bcm_scan against a cycle-position
// reference model of the BCM scan timing.
module tb_hub75_bcm_scan;

  localparam int COLS = 4;
  localparam int RB = 2;
  localparam int DEPTH = 2;
  localparam int BASE = 4;
  localparam int AW = RB + 2;
  localparam int DW = 6 * DEPTH;
  localparam int SHL = 2 * COLS + 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic [AW-1:0] rd_addr;
  logic rd_en;
  logic [DW-1:0] rd_data = '0;
  logic [5:0] rgb;
  logic [RB-1:0] lines;
  logic hub_ck, hub_st, hub_oe, frame_start;

  logic [DW-1:0] mem [2**AW];

  int n_chk = 0;
  int n_fail = 0;

  bit m_act;
  int m_pos, m_row, m_plane;
  logic [5:0] m_rgb;
  logic [RB-1:0] m_lines;

  int cyc = 0;
  int oe_run = 0;
  bit bp_on = 0;
  logic [RB-1:0] prev_lines;
  int fs_q[$];
  int oe_q[$];
  int st_q[$];

  hub75_bcm_scan #(
    .COLS(COLS), .ROW_BITS(RB), .DEPTH(DEPTH), .BASE_CYC(BASE)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .rgb(rgb), .lines(lines), .hub_ck(hub_ck),
    .hub_st(hub_st), .hub_oe(hub_oe), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int plen(int p);
    return 2 * COLS + 3 + (BASE << p);
  endfunction

  task automatic model_check();
    logic e_fs, e_en, e_ck, e_st, e_oe;
    logic [DW-1:0] w;
    e_fs = 0; e_en = 0; e_ck = 0; e_st = 0; e_oe = 1;
    if (m_act) begin
      if (m_pos < SHL) begin
        e_en = (m_pos % 2 == 0) && (m_pos < 2 * COLS);
        e_ck = (m_pos >= 2) && (m_pos % 2 == 1);
        e_fs = (m_pos == 0) && (m_row == 0) && (m_plane == 0);
        if (m_pos >= 2 && m_pos % 2 == 0) begin
          w = mem[m_row * COLS + (m_pos - 2) / 2];
          for (int i = 0; i < 6; i++)
            m_rgb[i] = w[i * DEPTH + m_plane];
        end
      end else if (m_pos == SHL) begin
        e_st = 1;
        m_lines = RB'(m_row);
      end else begin
        e_oe = 0;
      end
    end
    chk("ctl", {frame_start, rd_en, hub_ck, hub_st, hub_oe},
        {e_fs, e_en, e_ck, e_st, e_oe});
    chk("rgb", rgb, m_rgb);
    chk("lines", lines, m_lines);
    if (e_en) chk("addr", rd_addr, m_row * COLS + m_pos / 2);
    if (!m_act) chk("idle_addr", rd_addr, 0);
    chk("excl", (hub_ck & hub_st) | (!hub_oe & (hub_ck | hub_st)), 0);
  endtask

  task automatic model_step();
    if (!m_act) begin
      if (enable) begin
        m_act = 1; m_pos = 0; m_row = 0; m_plane = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == plen(m_plane)) begin
        m_pos = 0;
        if (enable) begin
          if (m_plane < DEPTH - 1) m_plane++;
          else begin
            m_plane = 0;
            m_row = (m_row + 1) % (1 << RB);
          end
        end else begin
          m_act = 0;
          m_rgb = '0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    model_check();
    if (frame_start) fs_q.push_back(cyc);
    if (!hub_oe) oe_run++;
    else if (oe_run > 0) begin
      oe_q.push_back(oe_run);
      oe_run = 0;
    end
    if (hub_st) st_q.push_back(int'(lines));
    if (lines !== prev_lines)
      chk("lchg", {hub_st, hub_oe}, 2'b11);
    prev_lines = lines;
    if (bp_on && m_act && m_row == 1 && m_pos == 7)
      chk(m_plane ? "bp1" : "bp0", rgb,
          m_plane ? 6'b000100 : 6'b000000);
  endtask

  task automatic clear_q();
    fs_q.delete(); oe_q.delete(); st_q.delete(); oe_run = 0;
  endtask

  task automatic model_reset();
    m_act = 0; m_pos = 0; m_row = 0; m_plane = 0;
    m_rgb = '0; m_lines = '0; prev_lines = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic chk_reset_vals(string pfx);
    chk({pfx, "_oe"}, hub_oe, 1);
    chk({pfx, "_rgb"}, rgb, 0);
    chk({pfx, "_lines"}, lines, 0);
    chk({pfx, "_ck"}, hub_ck, 0);
    chk({pfx, "_st"}, hub_st, 0);
    chk({pfx, "_fs"}, frame_start, 0);
    chk({pfx, "_rden"}, rd_en, 0);
    chk({pfx, "_addr"}, rd_addr, 0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    model_reset();

    resetn = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk_reset_vals("rst");

    clear_q();
    resetn = 1'b1;
    tick();
    chk("fs_first", frame_start, 1);
    chk("rd_first", {rd_en, rd_addr}, {1'b1, AW'(0)});
    repeat (271) tick();
    chk("fs_cnt", fs_q.size(), 2);
    chk("fs_per", fs_q.size() > 1 ? fs_q[1] - fs_q[0] : 0, 136);
    chk("oe_p0", oe_q.size() > 0 ? oe_q[0] : 0, 4);
    chk("oe_p1", oe_q.size() > 1 ? oe_q[1] : 0, 8);
    chk("st_cnt", st_q.size(), 16);
    for (int k = 0; k < 6; k++)
      chk("lseq", st_q.size() > 2 * k ? st_q[2 * k] : -1, k % 4);

    do_reset();
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    mem[1 * COLS + 2] = DW'(12'h020);
    bp_on = 1;
    repeat (136) tick();
    bp_on = 0;

    do_reset();
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = m_act && m_row == 2 && m_plane == 0 && m_pos == 4;
    end
    chk("seek_drop", found, 1);
    enable = 1'b0;
    clear_q();
    repeat (40) tick();
    chk("drop_show", oe_q.size() > 0 ? oe_q[0] : 0, 4);
    chk("drop_runs", oe_q.size(), 1);
    chk("drop_oe", hub_oe, 1);
    chk("drop_rgb", rgb, 0);
    enable = 1'b1;
    tick();
    chk("re_fs", frame_start, 1);
    chk("re_addr", {rd_en, rd_addr}, {1'b1, AW'(0)});
    repeat (60) tick();

    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = m_act && m_pos > SHL + 1;
    end
    chk("seek_show", found, 1);
    chk("show_oe", hub_oe, 0);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("arst");
    model_reset();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
